// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and data_memory signal bundle for dmem_arbiter
interface dmem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              busy;
  logic              gnt_port;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_memwrite;
  logic [DATA_W-1:0] mem_data_out;

  // arbiter side
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
    output ack0, ack1, rdata0, rdata1, busy, gnt_port,
    output mem_address, mem_write_data, mem_memwrite
  );

  // requesters plus the memory itself
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
    input  ack0, ack1, rdata0, rdata1, busy, gnt_port,
    input  mem_address, mem_write_data, mem_memwrite
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter and SETUP/ACCESS sequencer for data_memory
module dmem_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int FIXED_PRI = 0
) (
  input logic          clk,
  input logic          reset_n,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  localparam logic P_FIXED = (FIXED_PRI != 0);

  state_t            r_state;
  state_t            w_state_nxt;

  logic [ADDR_W-1:0] r_addr,     w_addr;
  logic [DATA_W-1:0] r_wdata,    w_wdata;
  logic              r_we,       w_we;
  logic              r_gnt,      w_gnt;
  logic              r_last,     w_last;
  logic              r_memwrite, w_memwrite;
  logic              r_ack0,     w_ack0;
  logic              r_ack1,     w_ack1;
  logic [DATA_W-1:0] r_rdata0,   w_rdata0;
  logic [DATA_W-1:0] r_rdata1,   w_rdata1;
  logic              r_busy,     w_busy;

  logic              w_elig0;
  logic              w_elig1;
  logic              w_win;

  // eligibility masks a port whose ack is out this cycle so a retiring request is not granted twice
  always_comb begin
    w_elig0 = bus.req0 & ~r_ack0;
    w_elig1 = bus.req1 & ~r_ack1;
    w_win   = w_elig1;
    if (w_elig0 && w_elig1) begin
      w_win = P_FIXED ? 1'b0 : ~r_last;
    end
  end

  // next-state and next-output decode for the IDLE -> SETUP -> ACCESS sequence
  always_comb begin
    w_state_nxt = r_state;
    w_addr      = r_addr;
    w_wdata     = r_wdata;
    w_we        = r_we;
    w_gnt       = r_gnt;
    w_last      = r_last;
    w_memwrite  = 1'b0;
    w_ack0      = 1'b0;
    w_ack1      = 1'b0;
    w_rdata0    = r_rdata0;
    w_rdata1    = r_rdata1;
    case (r_state)
      ST_IDLE: begin
        if (w_elig0 || w_elig1) begin
          w_state_nxt = ST_SETUP;
          w_gnt       = w_win;
          w_addr      = w_win ? bus.addr1  : bus.addr0;
          w_wdata     = w_win ? bus.wdata1 : bus.wdata0;
          w_we        = w_win ? bus.we1    : bus.we0;
        end
      end
      ST_SETUP: begin
        w_state_nxt = ST_ACCESS;
        w_memwrite  = r_we;
      end
      ST_ACCESS: begin
        w_state_nxt = ST_IDLE;
        w_last      = r_gnt;
        if (r_gnt) begin
          w_ack1 = 1'b1;
          if (!r_we) begin
            w_rdata1 = bus.mem_data_out;
          end
        end else begin
          w_ack0 = 1'b1;
          if (!r_we) begin
            w_rdata0 = bus.mem_data_out;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_busy = (w_state_nxt != ST_IDLE);
  end

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // registered outputs; last winner resets to port 1 so port 0 wins the first contest
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_gnt      <= 1'b0;
      r_last     <= 1'b1;
      r_memwrite <= 1'b0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_addr     <= w_addr;
      r_wdata    <= w_wdata;
      r_we       <= w_we;
      r_gnt      <= w_gnt;
      r_last     <= w_last;
      r_memwrite <= w_memwrite;
      r_ack0     <= w_ack0;
      r_ack1     <= w_ack1;
      r_rdata0   <= w_rdata0;
      r_rdata1   <= w_rdata1;
      r_busy     <= w_busy;
    end
  end

  assign bus.ack0           = r_ack0;
  assign bus.ack1           = r_ack1;
  assign bus.rdata0         = r_rdata0;
  assign bus.rdata1         = r_rdata1;
  assign bus.busy           = r_busy;
  assign bus.gnt_port       = r_gnt;
  assign bus.mem_address    = r_addr;
  assign bus.mem_write_data = r_wdata;
  assign bus.mem_memwrite   = r_memwrite;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter, round-robin and fixed-priority
module tb_dmem_arbiter;

  logic clk;
  logic reset_n;

  dmem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus_a ();
  dmem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus_b ();

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRI(0)) u_rr (
    .clk(clk), .reset_n(reset_n), .bus(bus_a.slave)
  );
  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRI(1)) u_fix (
    .clk(clk), .reset_n(reset_n), .bus(bus_b.slave)
  );

  // index [d][p]: d=0 round-robin DUT, d=1 fixed-priority DUT; p = port
  logic       req_q   [2][2];
  logic       we_q    [2][2];
  logic [7:0] addr_q  [2][2];
  logic [7:0] wdata_q [2][2];
  logic       ack_w   [2][2];
  logic [7:0] rdata_w [2][2];
  logic       busy_w     [2];
  logic       gnt_w      [2];
  logic       memwrite_w [2];
  logic [7:0] maddr_w    [2];
  logic [7:0] mwdata_w   [2];
  logic [7:0] mdout_w    [2];

  function automatic logic [7:0] init_val(input int a);
    return 8'(a * 4 + 15);
  endfunction

  assign bus_a.req0 = req_q[0][0];     assign bus_a.req1 = req_q[0][1];
  assign bus_a.we0 = we_q[0][0];       assign bus_a.we1 = we_q[0][1];
  assign bus_a.addr0 = addr_q[0][0];   assign bus_a.addr1 = addr_q[0][1];
  assign bus_a.wdata0 = wdata_q[0][0]; assign bus_a.wdata1 = wdata_q[0][1];
  assign bus_b.req0 = req_q[1][0];     assign bus_b.req1 = req_q[1][1];
  assign bus_b.we0 = we_q[1][0];       assign bus_b.we1 = we_q[1][1];
  assign bus_b.addr0 = addr_q[1][0];   assign bus_b.addr1 = addr_q[1][1];
  assign bus_b.wdata0 = wdata_q[1][0]; assign bus_b.wdata1 = wdata_q[1][1];

  assign ack_w[0][0] = bus_a.ack0;     assign ack_w[0][1] = bus_a.ack1;
  assign ack_w[1][0] = bus_b.ack0;     assign ack_w[1][1] = bus_b.ack1;
  assign rdata_w[0][0] = bus_a.rdata0; assign rdata_w[0][1] = bus_a.rdata1;
  assign rdata_w[1][0] = bus_b.rdata0; assign rdata_w[1][1] = bus_b.rdata1;
  assign busy_w[0] = bus_a.busy;       assign busy_w[1] = bus_b.busy;
  assign gnt_w[0] = bus_a.gnt_port;    assign gnt_w[1] = bus_b.gnt_port;
  assign memwrite_w[0] = bus_a.mem_memwrite;  assign memwrite_w[1] = bus_b.mem_memwrite;
  assign maddr_w[0] = bus_a.mem_address;      assign maddr_w[1] = bus_b.mem_address;
  assign mwdata_w[0] = bus_a.mem_write_data;  assign mwdata_w[1] = bus_b.mem_write_data;

  // data_memory stand-ins: combinational read, write on the edge while memwrite is high
  logic [7:0] mem_arr [2][256];
  bit         mem_wr  [2][256];
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (memwrite_w[d]) begin
        mem_arr[d][maddr_w[d]] <= mwdata_w[d];
        mem_wr[d][maddr_w[d]]  <= 1'b1;
      end
    end
  end
  assign mdout_w[0] = mem_wr[0][maddr_w[0]] ? mem_arr[0][maddr_w[0]] : init_val(int'(maddr_w[0]));
  assign mdout_w[1] = mem_wr[1][maddr_w[1]] ? mem_arr[1][maddr_w[1]] : init_val(int'(maddr_w[1]));
  assign bus_a.mem_data_out = mdout_w[0];
  assign bus_b.mem_data_out = mdout_w[1];

  // reference model state: memory contents per completed access, last read value, last winner
  logic [7:0] shadow  [2][256];
  logic [7:0] rd_last [2][2];
  int         lw      [2];

  int n_checks = 0;
  int n_errors = 0;
  int excl_bad = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ack_w[d][0] && ack_w[d][1]) excl_bad = excl_bad + 1;
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // single directed access; collects per-cycle observations until the ack
  task automatic do_access(input int d, input int p, input logic wr, input logic [7:0] a,
                           input logic [7:0] w, output int lat, output logic [7:0] rd,
                           output int n_busy, output int n_mw, output int n_bad);
    we_q[d][p] = wr; addr_q[d][p] = a; wdata_q[d][p] = w; req_q[d][p] = 1'b1;
    lat = 0; n_busy = 0; n_mw = 0; n_bad = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy_w[d]) n_busy++;
      if (memwrite_w[d]) n_mw++;
      if ((busy_w[d] || ack_w[d][p]) && (maddr_w[d] != a || mwdata_w[d] != w)) n_bad++;
      if (ack_w[d][1-p]) n_bad++;
    end while (!ack_w[d][p] && lat < 40);
    rd = rdata_w[d][p];
    req_q[d][p] = 1'b0;
    if (ack_w[d][p]) begin
      lw[d] = p;
      if (wr) shadow[d][a] = w;
      else rd_last[d][p] = shadow[d][a];
    end
  endtask

  // waits for any ack on DUT d; checks read data of the winner against the model
  task automatic wait_ack(input int d, output int port, output int t);
    port = -1; t = 0;
    do begin
      @(negedge clk);
      t++;
      if (ack_w[d][0]) port = 0;
      else if (ack_w[d][1]) port = 1;
    end while (port < 0 && t < 20);
    if (port >= 0) begin
      lw[d] = port;
      if (!we_q[d][port]) begin
        check_eq("arb_rdata", int'(rdata_w[d][port]), int'(shadow[d][addr_q[d][port]]));
        rd_last[d][port] = shadow[d][addr_q[d][port]];
      end
    end
  endtask

  task automatic pri_round(input int d, output int port);
    int t;
    for (int p = 0; p < 2; p++) begin
      we_q[d][p] = 1'b0; addr_q[d][p] = 8'(8'h20 + p); req_q[d][p] = 1'b1;
    end
    wait_ack(d, port, t);
    req_q[d][0] = 1'b0; req_q[d][1] = 1'b0;
    idle(2);
  endtask

  task automatic rand_port(input int d, input int p, input int n);
    int lat;
    int gap;
    logic wr;
    logic [7:0] a;
    logic [7:0] w;
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(0, 3);
      if (gap != 0) begin
        req_q[d][p] = 1'b0;
        repeat (gap) @(negedge clk);
      end
      wr = 1'($urandom_range(0, 1)); a = 8'($urandom_range(0, 15)); w = 8'($urandom);
      we_q[d][p] = wr; addr_q[d][p] = a; wdata_q[d][p] = w; req_q[d][p] = 1'b1;
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!ack_w[d][p] && lat < 200);
      check_eq("rand_ack_seen", int'(ack_w[d][p]), 1);
      if (ack_w[d][p]) begin
        lw[d] = p;
        if (wr) begin
          check_eq("rand_wr_keeps_rdata", int'(rdata_w[d][p]), int'(rd_last[d][p]));
          shadow[d][a] = w;
        end else begin
          check_eq("rand_rd_data", int'(rdata_w[d][p]), int'(shadow[d][a]));
          rd_last[d][p] = shadow[d][a];
        end
        if (d == 0 || p == 0) check_eq("rand_wait_bound", int'(lat >= 3 && lat <= 6), 1);
      end
    end
    req_q[d][p] = 1'b0;
  endtask

  initial begin
    int lat, n_busy, n_mw, n_bad, port, t, exp_p;
    logic [7:0] rd;

    reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      lw[d] = 1;
      for (int p = 0; p < 2; p++) begin
        req_q[d][p] = 1'b0; we_q[d][p] = 1'b0; addr_q[d][p] = 8'h00;
        wdata_q[d][p] = 8'h00; rd_last[d][p] = 8'h00;
      end
      for (int i = 0; i < 256; i++) shadow[d][i] = init_val(i);
    end

    // reset held with a pending request: everything zero, no ack
    req_q[0][0] = 1'b1; addr_q[0][0] = 8'h05;
    idle(3);
    for (int d = 0; d < 2; d++) begin
      check_eq("rst_ctrl", int'({ack_w[d][0], ack_w[d][1], busy_w[d], gnt_w[d], memwrite_w[d]}), 0);
      check_eq("rst_mem_addr", int'(maddr_w[d]), 0);
      check_eq("rst_mem_wdata", int'(mwdata_w[d]), 0);
      check_eq("rst_rdata", int'({rdata_w[d][0], rdata_w[d][1]}), 0);
    end
    reset_n = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ack_w[0][0] && lat < 10);
    check_eq("rst_first_lat", lat, 3);
    check_eq("rst_first_rdata", int'(rdata_w[0][0]), int'(shadow[0][5]));
    rd_last[0][0] = shadow[0][5]; lw[0] = 0;
    req_q[0][0] = 1'b0;
    idle(2);

    // port 0 read of 0x1C
    do_access(0, 0, 1'b0, 8'h1C, 8'h00, lat, rd, n_busy, n_mw, n_bad);
    check_eq("rd_lat", lat, 3);
    check_eq("rd_data", int'(rd), 8'h7F);
    check_eq("rd_no_memwrite", n_mw, 0);
    check_eq("rd_busy_cycles", n_busy, 2);
    check_eq("rd_stable", n_bad, 0);
    idle(2);

    // port 1 write 0x24 <= 0xE6, then port 0 read back
    do_access(0, 1, 1'b1, 8'h24, 8'hE6, lat, rd, n_busy, n_mw, n_bad);
    check_eq("wr_lat", lat, 3);
    check_eq("wr_memwrite_cycles", n_mw, 1);
    check_eq("wr_addr_data_stable", n_bad, 0);
    check_eq("wr_keeps_rdata1", int'(rd), int'(rd_last[0][1]));
    do_access(0, 0, 1'b0, 8'h24, 8'h00, lat, rd, n_busy, n_mw, n_bad);
    check_eq("wr_readback", int'(rd), 8'hE6);
    check_eq("wr_readback_lat", lat, 3);
    idle(2);

    // round-robin with both requests held: alternate, 3 cycles apart
    exp_p = 1 - lw[0];
    for (int p = 0; p < 2; p++) begin
      we_q[0][p] = 1'b0; addr_q[0][p] = 8'(8'h10 + p); req_q[0][p] = 1'b1;
    end
    for (int k = 0; k < 6; k++) begin
      wait_ack(0, port, t);
      check_eq("rr_alt_port", port, exp_p);
      check_eq("rr_alt_gap", t, 3);
      exp_p = 1 - exp_p;
    end
    req_q[0][0] = 1'b0; req_q[0][1] = 1'b0;
    idle(2);

    // simultaneous contests: round-robin alternates, fixed priority always port 0
    for (int k = 0; k < 4; k++) begin
      exp_p = 1 - lw[0];
      pri_round(0, port);
      check_eq("rr_contest_win", port, exp_p);
    end
    for (int k = 0; k < 4; k++) begin
      pri_round(1, port);
      check_eq("fix_contest_win", port, 0);
    end
    for (int p = 0; p < 2; p++) begin
      we_q[1][p] = 1'b0; addr_q[1][p] = 8'(8'h22 + p); req_q[1][p] = 1'b1;
    end
    wait_ack(1, port, t);
    check_eq("fix_first", port, 0);
    req_q[1][0] = 1'b0;
    wait_ack(1, port, t);
    check_eq("fix_port1_next", port, 1);
    check_eq("fix_port1_gap", t, 3);
    req_q[1][1] = 1'b0;
    idle(2);

    // random traffic on both DUTs
    fork
      rand_port(0, 0, 30);
      rand_port(0, 1, 30);
      rand_port(1, 0, 30);
      rand_port(1, 1, 30);
    join
    idle(3);

    // reset in the middle of a write access
    we_q[0][1] = 1'b1; addr_q[0][1] = 8'hFE; wdata_q[0][1] = 8'h0F; req_q[0][1] = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!memwrite_w[0] && t < 10);
    check_eq("midrst_reached_access", int'(memwrite_w[0]), 1);
    reset_n = 1'b0;
    #1;
    check_eq("midrst_memwrite_drop", int'(memwrite_w[0]), 0);
    check_eq("midrst_no_ack", int'(ack_w[0][1]), 0);
    req_q[0][1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_eq("midrst_hold_no_ack", int'({ack_w[0][1], busy_w[0]}), 0);
    end
    reset_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      lw[d] = 1;
      for (int p = 0; p < 2; p++) rd_last[d][p] = 8'h00;
    end
    @(negedge clk);
    check_eq("midrst_no_late_ack", int'({ack_w[0][1], busy_w[0]}), 0);
    do_access(0, 0, 1'b0, 8'h30, 8'h00, lat, rd, n_busy, n_mw, n_bad);
    check_eq("midrst_idle_lat", lat, 3);
    check_eq("midrst_rd_data", int'(rd), int'(shadow[0][8'h30]));
    idle(2);

    check_eq("ack_exclusive", excl_bad, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
